wb_ram_slave: RTL and testbench

- Wishbone B3 slave responder that wraps an inferred synchronous block RAM.
- Services single (classic) and registered-feedback incrementing-burst cycles issued by the Wishbone master.
- Gives host-side transfers a local memory target without external glue.
- Byte-lane writes; out-of-range accesses are terminated with an error response.

---
 rtl/wb_ram_slave.sv | 124 ++++++++++++
 tb/tb_wb_ram_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave wrapping a synchronous block RAM.
// Classic and registered-feedback incrementing bursts, byte-lane writes.
module wb_ram_slave #(
  parameter int DATA  = 16,
  parameter int ADDR  = 10,
  parameter int DEPTH = 2**ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR-1:0]   wb_adr_i,
  input  logic [DATA-1:0]   wb_dat_i,
  input  logic [DATA/8-1:0] wb_sel_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DATA-1:0]   wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int LANES = DATA / 8;
  localparam logic [ADDR:0] LIMIT = (ADDR+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } state_t;

  state_t state;

  logic [DATA-1:0] mem [DEPTH];

  logic [ADDR-1:0] beat;
  logic [ADDR-1:0] nxt;
  logic [ADDR-1:0] mask;
  logic [ADDR-1:0] rd_addr;
  logic [DATA-1:0] rd_data;
  logic            req;
  logic            adr_ok;
  logic            nxt_ok;
  logic            cti_inc;
  logic            commit;

  assign req     = wb_cyc_i & wb_stb_i;
  assign cti_inc = (wb_cti_i == 3'b010);
  assign commit  = req & wb_we_i & wb_ack_o;

  // Wrap bursts only advance the low k bits of the beat address.
  always_comb begin
    mask = '1;
    unique case (wb_bte_i)
      2'b01:   mask = ADDR'(3);
      2'b10:   mask = ADDR'(7);
      2'b11:   mask = ADDR'(15);
      default: mask = '1;
    endcase
    nxt = (beat & ~mask) | ((beat + ADDR'(1)) & mask);
  end

  assign adr_ok  = {1'b0, wb_adr_i} < LIMIT;
  assign nxt_ok  = {1'b0, nxt} < LIMIT;
  assign rd_addr = (state == BURST) ? nxt : wb_adr_i;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int l = 0; l < LANES; l++) begin
        if (wb_sel_i[l]) begin
          mem[beat][8*l +: 8] <= wb_dat_i[8*l +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            beat <= wb_adr_i;
            if (!adr_ok) begin
              wb_err_o <= 1'b1;
              state    <= SINGLE;
            end else begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= rd_data;
              state    <= cti_inc ? BURST : SINGLE;
            end
          end
        end
        SINGLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          state    <= IDLE;
        end
        BURST: begin
          if (req && cti_inc && nxt_ok) begin
            beat     <= nxt;
            wb_dat_o <= rd_data;
          end else begin
            wb_ack_o <= 1'b0;
            state    <= IDLE;
            // Burst walked off the end of memory.
            if (req && cti_inc) begin
              wb_err_o <= 1'b1;
              state    <= SINGLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: directed bus cycles, queued expectations,
// negedge monitors pop and compare each ack/err beat.
module tb_wb_ram_slave;

  typedef struct {
    int          cyc;
    bit          err;
    bit          chk;
    logic [15:0] dat;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tgt;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [9:0]  adr;
  logic [15:0] dat;
  logic [1:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [15:0] dat_a;
  logic        ack_a;
  logic        err_a;
  logic [15:0] dat_b;
  logic        ack_b;
  logic        err_b;

  int cyc_n = 0;
  int chk_n = 0;
  int fail_n = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic [15:0] vd [8];
  logic [15:0] ve [8];
  bit          vk [8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_ram_slave u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (cyc & ~tgt),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_a),
    .wb_ack_o (ack_a),
    .wb_err_o (err_a)
  );

  wb_ram_slave #(.DEPTH(1000)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (cyc & tgt),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_b),
    .wb_ack_o (ack_b),
    .wb_err_o (err_b)
  );

  function automatic void cmp(input exp_t e, input logic er,
                              input logic [15:0] d);
    chk_n++;
    if (er !== e.err || cyc_n != e.cyc || (e.chk && d !== e.dat)) begin
      fail_n++;
      $display("FAIL %s: got err=%0b cyc=%0d dat=%h, want err=%0b cyc=%0d dat=%h",
               e.nm, er, cyc_n, d, e.err, e.cyc, e.dat);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack_a || err_a)) begin
      if (ack_a && err_a) begin
        chk_n++;
        fail_n++;
        $display("FAIL dut_a both: got ack=1 err=1, want one");
      end else if (qa.size() == 0) begin
        chk_n++;
        fail_n++;
        $display("FAIL dut_a extra: got ack=%0b err=%0b, want none", ack_a, err_a);
      end else begin
        ea = qa.pop_front();
        cmp(ea, err_a, dat_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack_b || err_b)) begin
      if (ack_b && err_b) begin
        chk_n++;
        fail_n++;
        $display("FAIL dut_b both: got ack=1 err=1, want one");
      end else if (qb.size() == 0) begin
        chk_n++;
        fail_n++;
        $display("FAIL dut_b extra: got ack=%0b err=%0b, want none", ack_b, err_b);
      end else begin
        eb = qb.pop_front();
        cmp(eb, err_b, dat_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    chk_n++;
    if (got !== want) begin
      fail_n++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  function automatic logic [9:0] nx(input logic [9:0] a,
                                    input logic [1:0] b);
    case (b)
      2'b01:   return {a[9:2], a[1:0] + 2'd1};
      2'b10:   return {a[9:3], a[2:0] + 3'd1};
      2'b11:   return {a[9:4], a[3:0] + 4'd1};
      default: return a + 10'd1;
    endcase
  endfunction

  // Called and returns at posedge+1; beat i is expected at cycle c+1+i.
  task automatic xfer(input bit t, input bit w, input logic [9:0] a0,
                      input logic [1:0] b, input int n,
                      input logic [2:0] last, input logic [1:0] s,
                      input string nm);
    int c;
    logic [9:0] a;
    exp_t e;
    c = cyc_n;
    a = a0;
    for (int i = 0; i < n; i++) begin
      e.cyc = c + 1 + i;
      e.err = vk[i];
      e.chk = !w && !vk[i];
      e.dat = ve[i];
      e.nm  = $sformatf("%s.%0d", nm, i);
      if (t) qb.push_back(e);
      else qa.push_back(e);
    end
    tgt = t;
    we  = w;
    adr = a;
    dat = vd[0];
    sel = s;
    bte = b;
    cti = (n == 1) ? last : 3'b010;
    cyc = 1'b1;
    stb = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i < n - 1) begin
        a   = nx(a, b);
        adr = a;
        dat = vd[i+1];
        cti = (i + 1 == n - 1) ? last : 3'b010;
      end else begin
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
      end
    end
  endtask

  task automatic wr1(input bit t, input logic [9:0] a,
                     input logic [15:0] d, input logic [1:0] s,
                     input string nm);
    vd[0] = d;
    ve[0] = '0;
    vk[0] = 1'b0;
    xfer(t, 1'b1, a, 2'b00, 1, 3'b000, s, nm);
  endtask

  task automatic rd1(input bit t, input logic [9:0] a,
                     input logic [15:0] e, input bit k,
                     input string nm);
    vd[0] = '0;
    ve[0] = e;
    vk[0] = k;
    xfer(t, 1'b0, a, 2'b00, 1, 3'b000, 2'b11, nm);
  endtask

  task automatic setv(input int i, input logic [15:0] d,
                      input logic [15:0] e, input bit k);
    vd[i] = d;
    ve[i] = e;
    vk[i] = k;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int c;
    rst_n = 1'b0;
    tgt = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    adr = '0;
    dat = '0;
    sel = '0;
    cti = '0;
    bte = '0;
    #12;
    chk("rst ack_a", {15'd0, ack_a}, 16'd0);
    chk("rst err_a", {15'd0, err_a}, 16'd0);
    chk("rst dat_a", dat_a, 16'd0);
    chk("rst ack_b", {15'd0, ack_b}, 16'd0);
    chk("rst err_b", {15'd0, err_b}, 16'd0);
    chk("rst dat_b", dat_b, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    wr1(0, 10'd5, 16'hBEEF, 2'b11, "wr5");
    rd1(0, 10'd5, 16'hBEEF, 0, "rd5");

    wr1(0, 10'd7, 16'h1234, 2'b11, "wr7");
    wr1(0, 10'd7, 16'hAB00, 2'b10, "wr7hi");
    rd1(0, 10'd7, 16'hAB34, 0, "rd7");

    for (int i = 0; i < 4; i++) setv(i, 16'(8 + i), '0, 0);
    xfer(0, 1'b1, 10'd8, 2'b00, 4, 3'b111, 2'b11, "lin_wr");

    for (int i = 0; i < 4; i++) setv(i, '0, 16'(8 + i), 0);
    xfer(0, 1'b0, 10'd8, 2'b00, 4, 3'b111, 2'b11, "lin_rd");

    setv(0, 16'hAAAA, '0, 0);
    setv(1, 16'hBBBB, '0, 0);
    setv(2, 16'hCCCC, '0, 0);
    setv(3, 16'hDDDD, '0, 0);
    xfer(0, 1'b1, 10'd6, 2'b01, 4, 3'b111, 2'b11, "wrap4_wr");
    rd1(0, 10'd4, 16'hCCCC, 0, "rd4");
    rd1(0, 10'd5, 16'hDDDD, 0, "rd5w");
    rd1(0, 10'd6, 16'hAAAA, 0, "rd6");
    rd1(0, 10'd7, 16'hBBBB, 0, "rd7w");
    rd1(0, 10'd8, 16'h0008, 0, "rd8");

    rd1(1, 10'd1000, '0, 1, "b_oor");
    wr1(1, 10'd998, 16'h03E6, 2'b11, "b_wr998");
    wr1(1, 10'd999, 16'h03E7, 2'b11, "b_wr999");
    setv(0, '0, 16'h03E6, 0);
    setv(1, '0, 16'h03E7, 0);
    setv(2, '0, '0, 1);
    xfer(1, 1'b0, 10'd998, 2'b00, 3, 3'b010, 2'b11, "b_burst");

    wr1(0, 10'd21, 16'h5555, 2'b11, "wr21");
    c = cyc_n;
    e.err = 1'b0;
    e.chk = 1'b0;
    e.dat = '0;
    e.cyc = c + 1;
    e.nm  = "drop.0";
    qa.push_back(e);
    e.cyc = c + 2;
    e.nm  = "drop.1";
    qa.push_back(e);
    tgt = 1'b0;
    we  = 1'b1;
    adr = 10'd20;
    dat = 16'h1111;
    sel = 2'b11;
    bte = 2'b00;
    cti = 3'b010;
    cyc = 1'b1;
    stb = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    adr = 10'd21;
    dat = 16'h2222;
    cyc = 1'b0;
    @(posedge clk);
    #1;
    chk("drop ack low", {15'd0, ack_a}, 16'd0);
    stb = 1'b0;
    we  = 1'b0;
    cti = 3'b000;
    rd1(0, 10'd20, 16'h1111, 0, "rd20");
    rd1(0, 10'd21, 16'h5555, 0, "rd21");

    c = cyc_n;
    e.err = 1'b0;
    e.chk = 1'b1;
    e.dat = 16'h0008;
    e.cyc = c + 1;
    e.nm  = "rst_b0";
    qa.push_back(e);
    we  = 1'b0;
    adr = 10'd8;
    bte = 2'b00;
    cti = 3'b010;
    cyc = 1'b1;
    stb = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst ack", {15'd0, ack_a}, 16'd0);
    chk("mid rst err", {15'd0, err_a}, 16'd0);
    chk("mid rst dat", dat_a, 16'd0);
    cyc = 1'b0;
    stb = 1'b0;
    cti = 3'b000;
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd1(0, 10'd8, 16'h0008, 0, "rd8_post");

    repeat (4) @(posedge clk);
    #1;
    chk("qa drained", 16'(qa.size()), 16'd0);
    chk("qb drained", 16'(qb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $finish;
  end

endmodule
